regfile_param: RTL

- Parametrised general-purpose register file for the datapath.
- Two combinational read ports and two synchronous write ports.
- Register 0 is hardwired to zero.
- Optional same-cycle write-to-read bypass.
- Reset-triggered clear sequencer zeroes the array one entry per cycle and flags readiness to the pipeline.

---
 rtl/regfile_param_if.sv | 29 ++
 rtl/regfile_param.sv | 92 +++++++++
 2 files changed

// File: rtl/regfile_param_if.sv
// Register-file access bundle: two write ports, two read ports, and status flags.
// The pipeline side is the master and the register file is the slave.
interface regfile_param_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              we0;
   logic [ADDR_W-1:0] waddr0;
   logic [DATA_W-1:0] wdata0;
   logic              we1;
   logic [ADDR_W-1:0] waddr1;
   logic [DATA_W-1:0] wdata1;
   logic [ADDR_W-1:0] raddr0;
   logic [DATA_W-1:0] rdata0;
   logic [ADDR_W-1:0] raddr1;
   logic [DATA_W-1:0] rdata1;
   logic              ready;
   logic              busy_clear;

   modport master (
      output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr0, raddr1,
      input  rdata0, rdata1, ready, busy_clear
   );

   modport slave (
      input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr0, raddr1,
      output rdata0, rdata1, ready, busy_clear
   );
endinterface

// File: rtl/regfile_param.sv
// Parametrised 2R/2W register file with register 0 hardwired to zero and an
// optional write-to-read bypass. A clear sequencer walks the array after reset.
module regfile_param #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 5,
   parameter bit BYPASS         = 1'b1,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input logic             clk,
   input logic             rst_n,
   regfile_param_if.slave  bus
);
   localparam int NUM_REGS = 2**ADDR_W;

   typedef enum logic [1:0] {
      IDLE_RST = 2'd0,
      CLEAR    = 2'd1,
      READY    = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] clr_idx;
   logic              ready_int;
   logic              busy_int;
   logic [DATA_W-1:0] mem [NUM_REGS];
   logic [ADDR_W-1:0] raddr [2];
   logic [DATA_W-1:0] rdata [2];

   always_ff @(posedge clk) begin
      if (!rst_n) state <= CLEAR_ON_RESET ? CLEAR : IDLE_RST;
      else        state <= state_nxt;
   end

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case leaves a value held and no latch is inferred.
   always_comb begin
      state_nxt = state;
      ready_int = 1'b0;
      busy_int  = 1'b0;
      case (state)
         IDLE_RST: state_nxt = READY;
         CLEAR: begin
            busy_int = 1'b1;
            if (clr_idx == '1) state_nxt = READY;
         end
         READY:    ready_int = 1'b1;
         default:  state_nxt = IDLE_RST;
      endcase
   end

   // Index 0 is never stored, so the walk starts at 1 and ends at the top entry.
   always_ff @(posedge clk) begin
      if (!rst_n)              clr_idx <= ADDR_W'(1);
      else if (state == CLEAR) clr_idx <= clr_idx + ADDR_W'(1);
   end

   // NOTE: the array has no reset term; zeroing it is the clear sequencer's job,
   // which keeps the storage a plain RAM-style structure without per-bit resets.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == CLEAR) begin
            mem[clr_idx] <= '0;
         end else if (state == READY) begin
            // NOTE: non-blocking writes resolve in source order, so placing port 1
            // last gives it priority when both ports target the same address.
            if (bus.we0 && bus.waddr0 != '0) mem[bus.waddr0] <= bus.wdata0;
            if (bus.we1 && bus.waddr1 != '0) mem[bus.waddr1] <= bus.wdata1;
         end
      end
   end

   assign raddr[0] = bus.raddr0;
   assign raddr[1] = bus.raddr1;

   // Reads are forced to zero for address 0 and until the array is initialised.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdata[p] = '0;
         if (ready_int && raddr[p] != '0) begin
            if (BYPASS && bus.we1 && bus.waddr1 == raddr[p])      rdata[p] = bus.wdata1;
            else if (BYPASS && bus.we0 && bus.waddr0 == raddr[p]) rdata[p] = bus.wdata0;
            else                                                  rdata[p] = mem[raddr[p]];
         end
      end
   end

   assign bus.rdata0     = rdata[0];
   assign bus.rdata1     = rdata[1];
   assign bus.ready      = ready_int;
   assign bus.busy_clear = busy_int;
endmodule
